// File: rtl/sd_sector_buffer.sv
// Single-sector read cache in front of an SD block interface: a hit answers from
// the 512-byte sector RAM, a miss refills the whole sector from the SD byte stream.
module sd_sector_buffer #(
  parameter int unsigned ADDR_MODE = 0,
  parameter logic [23:0] TIMEOUT   = 24'd2000000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req,
  input  logic [31:0] req_addr,
  input  logic        invalidate,
  output logic        ready,
  output logic        ack,
  output logic [7:0]  rdata,
  output logic        err,
  input  logic        sd_idle,
  input  logic        sd_valid_read,
  input  logic        sd_byte_stb,
  input  logic [7:0]  sd_byte,
  output logic        sd_begin_read,
  output logic [31:0] sd_addr
);

  typedef enum logic [2:0] {IDLE, LOOKUP, ISSUE, FILL, RESP, ERR} state_t;

  state_t      state;
  logic [7:0]  ram [0:511];
  logic [22:0] tag;
  logic        valid;
  logic        pend_inv;
  logic        force_hit;
  logic [9:0]  count;
  logic [23:0] timer;
  logic [22:0] lat_sector;
  logic [8:0]  lat_offset;
  logic        wr_en;
  logic        last_byte;
  logic        hit;

  function automatic logic [31:0] block_addr(input logic [22:0] sector);
    if (ADDR_MODE == 1) return {9'd0, sector};
    else                return {sector, 9'd0};
  endfunction

  // count[9] set means the sector is already full: further strobes are dropped
  assign wr_en     = (state == FILL) && sd_byte_stb && sd_valid_read && !count[9];
  assign last_byte = wr_en && (count == 10'd511);
  // A just-completed fill answers its own request even if invalidated meanwhile
  assign hit       = force_hit || (valid && (tag == lat_sector));

  always_ff @(posedge clock) begin
    if (wr_en) ram[count[8:0]] <= sd_byte;
  end

  always_ff @(posedge clock) begin
    if (state == IDLE && req) begin
      lat_sector <= req_addr[31:9];
      lat_offset <= req_addr[8:0];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      valid         <= 1'b0;
      tag           <= '0;
      count         <= '0;
      timer         <= '0;
      pend_inv      <= 1'b0;
      force_hit     <= 1'b0;
      ready         <= 1'b1;
      ack           <= 1'b0;
      err           <= 1'b0;
      rdata         <= '0;
      sd_begin_read <= 1'b0;
      sd_addr       <= '0;
    end else begin
      ack           <= 1'b0;
      err           <= 1'b0;
      rdata         <= '0;
      sd_begin_read <= 1'b0;
      case (state)
        IDLE: begin
          if (invalidate) valid <= 1'b0;
          if (req) begin
            ready <= 1'b0;
            state <= LOOKUP;
          end
        end
        LOOKUP: begin
          force_hit <= 1'b0;
          if (invalidate) valid <= 1'b0;
          if (hit) begin
            ack   <= 1'b1;
            rdata <= ram[lat_offset];
            state <= RESP;
          end else begin
            sd_addr  <= block_addr(lat_sector);
            pend_inv <= 1'b0;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          valid <= 1'b0;
          if (invalidate) pend_inv <= 1'b1;
          if (sd_idle) begin
            sd_begin_read <= 1'b1;
            count         <= '0;
            timer         <= '0;
            state         <= FILL;
          end
        end
        FILL: begin
          if (invalidate) pend_inv <= 1'b1;
          timer <= timer + 24'd1;
          if (wr_en) count <= count + 10'd1;
          if (last_byte) begin
            tag       <= lat_sector;
            valid     <= !(pend_inv || invalidate);
            pend_inv  <= 1'b0;
            force_hit <= 1'b1;
            state     <= LOOKUP;
          // the error ack is registered, so it becomes visible in FILL cycle TIMEOUT
          end else if (timer == TIMEOUT - 24'd1) begin
            ack   <= 1'b1;
            err   <= 1'b1;
            state <= ERR;
          end
        end
        RESP: begin
          if (invalidate) valid <= 1'b0;
          ready <= 1'b1;
          state <= IDLE;
        end
        ERR: begin
          ready <= 1'b1;
          state <= IDLE;
        end
        default: begin
          ready <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sd_sector_buffer.sv
// Randomized bench for sd_sector_buffer: a cache model (valid/tag/512-byte array)
// predicts hit or miss, refill address and returned byte for every request.
module tb_sd_sector_buffer;

  localparam logic [23:0] TO0 = 24'd4000;
  localparam logic [23:0] TO1 = 24'd100;

  logic        clock = 1'b0;
  logic        reset;
  logic        req0, req1, inv0, inv1;
  logic [31:0] req_addr;
  logic        sd_idle, sd_valid_read, sd_byte_stb;
  logic [7:0]  sd_byte;
  logic        ready0, ack0, err0, begin0;
  logic [7:0]  rdata0;
  logic [31:0] addr0;
  logic        ready1, ack1, err1, begin1;
  logic [7:0]  rdata1;
  logic [31:0] addr1;

  always #5 clock = ~clock;

  sd_sector_buffer #(.ADDR_MODE(0), .TIMEOUT(TO0)) dut (
    .clock(clock), .reset(reset), .req(req0), .req_addr(req_addr), .invalidate(inv0),
    .ready(ready0), .ack(ack0), .rdata(rdata0), .err(err0),
    .sd_idle(sd_idle), .sd_valid_read(sd_valid_read), .sd_byte_stb(sd_byte_stb),
    .sd_byte(sd_byte), .sd_begin_read(begin0), .sd_addr(addr0));

  sd_sector_buffer #(.ADDR_MODE(1), .TIMEOUT(TO1)) dut1 (
    .clock(clock), .reset(reset), .req(req1), .req_addr(req_addr), .invalidate(inv1),
    .ready(ready1), .ack(ack1), .rdata(rdata1), .err(err1),
    .sd_idle(sd_idle), .sd_valid_read(sd_valid_read), .sd_byte_stb(sd_byte_stb),
    .sd_byte(sd_byte), .sd_begin_read(begin1), .sd_addr(addr1));

  int n_tests = 0;
  int n_fail  = 0;
  int ack_cnt0 = 0;
  int beg_cnt0 = 0;

  always @(posedge clock) begin
    if (ack0)   ack_cnt0 <= ack_cnt0 + 1;
    if (begin0) beg_cnt0 <= beg_cnt0 + 1;
  end

  bit          m_valid;
  logic [22:0] m_tag;
  logic [7:0]  m_data [512];
  logic [7:0]  m_new  [512];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clock);
  endtask

  task automatic stream0(input int extra, input int inv_at, input int rst_at,
                         output bit aborted, output int got, output logic [7:0] rd, output logic er);
    int  sent;
    int  r;
    bit  inv_done;
    bit  early;
    sent = 0; inv_done = 0; early = 0; aborted = 0; got = 0; rd = '0; er = 1'b0;
    while (sent < 512) begin
      if (sent == rst_at) begin
        sd_byte_stb = 1'b0; inv0 = 1'b0; reset = 1'b1;
        tick();
        check("rst_ready", ready0, 1);
        check("rst_ack", ack0, 0);
        check("rst_err", err0, 0);
        check("rst_begin", begin0, 0);
        check("rst_addr", addr0, 0);
        check("rst_rdata", rdata0, 0);
        reset = 1'b0;
        for (int j = 0; j < 5; j++) begin
          sd_byte_stb = 1'b1; sd_valid_read = 1'b1; sd_byte = 8'h3C;
          tick();
          if (ack0) early = 1;
        end
        sd_byte_stb = 1'b0;
        tick();
        check("rst_no_ack", early, 0);
        check("rst_ready_after", ready0, 1);
        aborted = 1;
        return;
      end
      r = $urandom_range(0, 3);
      inv0 = (sent == inv_at) && !inv_done;
      if (inv0) inv_done = 1;
      sd_byte_stb   = (r != 0);
      sd_valid_read = (r >= 2);
      sd_byte       = (r >= 2) ? m_new[sent] : 8'($urandom);
      if (r >= 2) sent++;
      tick();
      if (ack0 || ready0) early = 1;
    end
    inv0 = 1'b0;
    for (int j = 0; j < 12; j++) begin
      sd_byte_stb   = (j < extra);
      sd_valid_read = 1'b1;
      sd_byte       = ~m_new[j];
      tick();
      if (ack0) begin
        got++;
        rd = rdata0;
        er = err0;
      end
    end
    sd_byte_stb = 1'b0;
    check("fill_quiet", early, 0);
  endtask

  task automatic access0(input logic [31:0] a, input bit inv_with_req, input int idle_delay,
                         input int extra, input int inv_at, input int rst_at, input bit ramp,
                         input string tag);
    logic [22:0] sector;
    logic [8:0]  off;
    bit          hit, found, bad, aborted;
    int          b0, a0, got;
    logic [7:0]  rd;
    logic        er;
    sector = a[31:9];
    off    = a[8:0];
    for (int k = 0; k < 50 && !ready0; k++) tick();
    check({tag, "_ready"}, ready0, 1);
    if (inv_with_req) m_valid = 0;
    hit = m_valid && (m_tag == sector);
    b0 = beg_cnt0;
    a0 = ack_cnt0;
    if (!hit && idle_delay > 0) sd_idle = 1'b0;
    req0 = 1'b1; req_addr = a; inv0 = inv_with_req;
    tick();
    req0 = 1'b0; inv0 = 1'b0; req_addr = $urandom;
    if (hit) begin
      check({tag, "_hit_t1"}, ack0, 0);
      tick();
      check({tag, "_hit_ack"}, ack0, 1);
      check({tag, "_hit_rdata"}, rdata0, m_data[off]);
      check({tag, "_hit_err"}, err0, 0);
      tick();
      check({tag, "_hit_ack_end"}, ack0, 0);
      check({tag, "_hit_ready"}, ready0, 1);
      check({tag, "_hit_no_read"}, beg_cnt0 - b0, 0);
      check({tag, "_hit_acks"}, ack_cnt0 - a0, 1);
    end else begin
      bad = 0;
      for (int k = 0; k < idle_delay; k++) begin
        if (begin0 || ready0) bad = 1;
        tick();
      end
      if (idle_delay > 0) begin
        check({tag, "_stall"}, bad, 0);
        sd_idle = 1'b1;
      end
      found = 0;
      for (int k = 0; k < 10; k++) begin
        if (begin0) begin
          found = 1;
          break;
        end
        tick();
      end
      check({tag, "_begin"}, found, 1);
      if (!found) return;
      check({tag, "_sd_addr"}, addr0, {sector, 9'd0});
      for (int i = 0; i < 512; i++) m_new[i] = ramp ? 8'(i) : 8'($urandom);
      stream0(extra, inv_at, rst_at, aborted, got, rd, er);
      if (aborted) begin
        m_valid = 0;
        check({tag, "_abort_acks"}, ack_cnt0 - a0, 0);
        return;
      end
      m_data  = m_new;
      m_valid = (inv_at < 0);
      m_tag   = sector;
      check({tag, "_miss_acks_seen"}, got, 1);
      check({tag, "_miss_rdata"}, rd, m_data[off]);
      check({tag, "_miss_err"}, er, 0);
      check({tag, "_miss_acks"}, ack_cnt0 - a0, 1);
      check({tag, "_miss_reads"}, beg_cnt0 - b0, 1);
    end
  endtask

  task automatic access1(input logic [31:0] a, input string tag);
    bit found;
    int n;
    for (int k = 0; k < 50 && !ready1; k++) tick();
    req1 = 1'b1; req_addr = a;
    tick();
    req1 = 1'b0;
    found = 0;
    for (int k = 0; k < 10; k++) begin
      if (begin1) begin
        found = 1;
        break;
      end
      tick();
    end
    check({tag, "_begin"}, found, 1);
    if (!found) return;
    check({tag, "_sd_addr"}, addr1, {9'd0, a[31:9]});
    n = 0;
    found = 0;
    while (n < 300 && !found) begin
      sd_byte_stb = (n < 10); sd_valid_read = 1'b1; sd_byte = 8'(n);
      tick();
      n++;
      if (ack1) found = 1;
    end
    sd_byte_stb = 1'b0;
    check({tag, "_ack_seen"}, found, 1);
    check({tag, "_latency"}, (n >= int'(TO1) && n <= int'(TO1) + 1), 1);
    check({tag, "_err"}, err1, 1);
    check({tag, "_rdata"}, rdata1, 0);
    tick();
    check({tag, "_ack_end"}, ack1, 0);
    check({tag, "_ready"}, ready1, 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; req0 = 1'b0; req1 = 1'b0; inv0 = 1'b0; inv1 = 1'b0; req_addr = '0;
    sd_idle = 1'b1; sd_valid_read = 1'b0; sd_byte_stb = 1'b0; sd_byte = '0;
    m_valid = 0; m_tag = '0;
    tick();
    tick();
    check("reset_ready", ready0, 1);
    check("reset_ack", ack0, 0);
    check("reset_err", err0, 0);
    check("reset_rdata", rdata0, 0);
    check("reset_begin", begin0, 0);
    check("reset_addr", addr0, 0);
    check("reset_ready1", ready1, 1);
    check("reset_addr1", addr1, 0);
    reset = 1'b0;
    tick();

    access0(32'h0000_0405, 0, 0, 0, -1, -1, 1, "miss_ramp");
    access0(32'h0000_05FF, 0, 0, 0, -1, -1, 0, "hit_ff");
    for (int i = 0; i < 4; i++) access0({23'd2, 9'($urandom)}, 0, 0, 0, -1, -1, 0, "hit_rand");

    inv0 = 1'b1;
    tick();
    inv0 = 1'b0;
    m_valid = 0;
    tick();
    access0({23'd2, 9'($urandom)}, 0, 50, 0, -1, -1, 0, "inv_idle_stall");
    access0({23'd2, 9'($urandom)}, 0, 0, 0, -1, -1, 0, "hit_after_refill");
    access0({23'd2, 9'($urandom)}, 1, 0, 0, -1, -1, 0, "inv_with_req");
    access0({23'd7, 9'($urandom)}, 0, 0, 0, 300, -1, 0, "inv_in_fill");
    access0({23'd7, 9'($urandom)}, 0, 0, 2, -1, -1, 0, "refill_extra");
    access0({23'd7, 9'd0}, 0, 0, 0, -1, -1, 0, "extra_b0");
    access0({23'd7, 9'd1}, 0, 0, 0, -1, -1, 0, "extra_b1");
    for (int i = 0; i < 5; i++)
      access0({23'($urandom_range(7, 8)), 9'($urandom)}, 0, 0, 0, -1, -1, 0, "rand_mix");
    access0({23'd5, 9'($urandom)}, 0, 0, 0, -1, 200, 0, "rst_mid_fill");
    access0({23'd5, 9'($urandom)}, 0, 0, 0, -1, -1, 0, "after_rst");
    access0({23'd5, 9'($urandom)}, 0, 0, 0, -1, -1, 0, "hit_after_rst");

    access1(32'h0000_1203, "timeout_first");
    access1(32'h0000_1203, "timeout_again");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
